conv2_fmap_writer: RTL and testbench

- Writer side of the layer-3 feature-map buffer, sitting between the conv2 output stream and the 128-entry layer-3 RAM that the ReLU/2x2 max-pool stage reads.
- Stores the 24x24 conv2 output row-major into a two-slot ring of row pairs: slot A covers rows 2k and 2k+1 at addresses 0..47; slot B covers the next pair at 48..95.
- Generates the conv_2_ready and conv_2_write_complete handshakes the pool stage waits on.
- Applies backpressure so an unconsumed row pair is never overwritten.

---
 rtl/conv2_fmap_writer_if.sv | 30 +++
 rtl/conv2_fmap_writer.sv | 162 ++++++++++++++++
 tb/tb_conv2_fmap_writer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv2_fmap_writer_if.sv
// conv2_fmap_writer_if: stream-in / RAM-write / pool handshake bundle for the
// layer-3 feature-map writer.
//   slave  : the writer block (consumes the conv2 stream, drives the RAM port)
//   master : the surrounding environment (conv2 source, pool stage, RAM)
interface conv2_fmap_writer_if #(
  parameter int unsigned ADDR_W = 7
);
  logic              layer_3_write_begin;
  logic [7:0]        d_in;
  logic              d_in_valid;
  logic              d_in_ready;
  logic              pair_consumed;
  logic              wr_en;
  logic [ADDR_W-1:0] layer_3_write_addr;
  logic [7:0]        d_out;
  logic              conv_2_ready;
  logic              conv_2_write_complete;

  modport slave (
    input  layer_3_write_begin, d_in, d_in_valid, pair_consumed,
    output d_in_ready, wr_en, layer_3_write_addr, d_out,
           conv_2_ready, conv_2_write_complete
  );

  modport master (
    output layer_3_write_begin, d_in, d_in_valid, pair_consumed,
    input  d_in_ready, wr_en, layer_3_write_addr, d_out,
           conv_2_ready, conv_2_write_complete
  );
endinterface

// File: rtl/conv2_fmap_writer.sv
// conv2_fmap_writer: writes the conv2 output frame row-major into a two-slot
// ring of row pairs (slot A at 0.., slot B at SLOT_B_BASE..) of the layer-3
// RAM, raises conv_2_ready once the first pair is stored, raises
// conv_2_write_complete after the last row, and backpressures the stream so
// an unconsumed row pair is never overwritten.
// Optional build macro: CONV2_WR_RELU_EN -- clamp negative (bit7=1) pixels
// to zero before writing, so the buffer holds post-ReLU data.
module conv2_fmap_writer #(
  parameter int unsigned ROW_LEN     = 24,
  parameter int unsigned ROW_CNT     = 24,
  parameter int unsigned SLOT_B_BASE = 48,
  parameter int unsigned ADDR_W      = 7
) (
  input  logic                clk,
  input  logic                rst,
  conv2_fmap_writer_if.slave  bus
);

  localparam int unsigned COL_W = $clog2(ROW_LEN);
  localparam int unsigned ROW_W = $clog2(ROW_CNT);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_LEN - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROW_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STALL,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              wr_slot_q, wr_slot_d;
  logic              rd_slot_q, rd_slot_d;
  logic [1:0]        full_q, full_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic              ready_q, ready_d;
  logic              complete_q, complete_d;

  logic              in_ready;
  logic              accept;
  logic              wr_slot_n;
  logic [7:0]        pix;

`ifdef CONV2_WR_RELU_EN
  assign pix = bus.d_in[7] ? '0 : bus.d_in;
`else
  assign pix = bus.d_in;
`endif

  // Ready depends only on registered state, never on d_in_valid.
  assign in_ready  = (state_q == FILL) && !full_q[wr_slot_q];
  assign accept    = bus.d_in_valid && in_ready;
  assign wr_slot_n = ~wr_slot_q;

  assign bus.d_in_ready            = in_ready;
  assign bus.wr_en                 = wr_en_q;
  assign bus.layer_3_write_addr    = addr_q;
  assign bus.d_out                 = dout_q;
  assign bus.conv_2_ready          = ready_q;
  assign bus.conv_2_write_complete = complete_q;

  // Next-state: counters, slot ring bookkeeping, write port and handshakes.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    wr_slot_d  = wr_slot_q;
    rd_slot_d  = rd_slot_q;
    full_d     = full_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    dout_d     = dout_q;
    ready_d    = ready_q;
    complete_d = complete_q;

    if (state_q == IDLE || !bus.layer_3_write_begin) begin
      // Idle, or begin dropped (abort / end of DONE): clear everything.
      col_d      = '0;
      row_d      = '0;
      wr_slot_d  = 1'b0;
      rd_slot_d  = 1'b0;
      full_d     = '0;
      addr_d     = '0;
      dout_d     = '0;
      ready_d    = 1'b0;
      complete_d = 1'b0;
      state_d    = (state_q == IDLE && bus.layer_3_write_begin) ? FILL : IDLE;
    end else begin
      // Release is applied before a same-cycle completion so a pair can land
      // in the slot being freed without stalling.
      if (bus.pair_consumed && (full_q != '0)) begin
        full_d[rd_slot_q] = 1'b0;
        rd_slot_d         = ~rd_slot_q;
      end

      if (accept) begin
        wr_en_d = 1'b1;
        dout_d  = pix;
        addr_d  = (wr_slot_q ? ADDR_W'(SLOT_B_BASE) : '0)
                + (row_q[0] ? ADDR_W'(ROW_LEN) : '0)
                + ADDR_W'(col_q);
        if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = row_q + 1'b1;
          if (row_q[0]) begin
            full_d[wr_slot_q] = 1'b1;
            wr_slot_d         = wr_slot_n;
            ready_d           = 1'b1;
            if (row_q == LAST_ROW) begin
              state_d = DONE;
            end else if (full_d[wr_slot_n]) begin
              state_d = STALL;
            end
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      if (state_q == STALL && !full_q[wr_slot_q]) begin
        state_d = FILL;
      end
      if (state_q == DONE) begin
        complete_d = 1'b1;
      end
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      wr_slot_q  <= 1'b0;
      rd_slot_q  <= 1'b0;
      full_q     <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      ready_q    <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      full_q     <= full_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      ready_q    <= ready_d;
      complete_q <= complete_d;
    end
  end

endmodule

// File: tb/tb_conv2_fmap_writer.sv
// Directed bench for conv2_fmap_writer: reset, first pair, stall on a full
// ring, release, full frame with completion, abort/restart, pixel clamp.
module tb_conv2_fmap_writer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  conv2_fmap_writer_if #(.ADDR_W(7)) bus ();

  conv2_fmap_writer #(
    .ROW_LEN(24),
    .ROW_CNT(24),
    .SLOT_B_BASE(48),
    .ADDR_W(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected RAM data for a given input pixel.
  function automatic logic [7:0] exp_pix(input logic [7:0] v);
`ifdef CONV2_WR_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    bus.layer_3_write_begin = 1'b1;
    bus.d_in = 8'h55;
    bus.d_in_valid = 1'b1;
    bus.pair_consumed = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.wr_en !== 1'b0 || bus.d_in_ready !== 1'b0 || bus.conv_2_ready !== 1'b0 ||
        bus.conv_2_write_complete !== 1'b0 || bus.layer_3_write_addr !== 7'd0 || bus.d_out !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: wr_en=%b rdy=%b c2r=%b cmp=%b addr=%0d dout=%h required all 0",
               bus.wr_en, bus.d_in_ready, bus.conv_2_ready, bus.conv_2_write_complete,
               bus.layer_3_write_addr, bus.d_out);
    end
    bus.d_in_valid = 1'b0;
    bus.layer_3_write_begin = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  // Async reset taken mid-stream must clear outputs without a clock edge.
  task automatic test_async_reset();
    bus.layer_3_write_begin = 1'b1;
    tick();
    bus.d_in = 8'h21;
    bus.d_in_valid = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.wr_en !== 1'b0 || bus.layer_3_write_addr !== 7'd0 || bus.d_in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: wr_en=%b addr=%0d rdy=%b required 0 0 0",
               bus.wr_en, bus.layer_3_write_addr, bus.d_in_ready);
    end
    bus.d_in_valid = 1'b0;
    bus.layer_3_write_begin = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  // Streams pixels first..last (value = index), expecting addresses index-1.
  task automatic stream_check(input int first, input int last, input int ready_at);
    for (int i = first; i <= last; i++) begin
      bus.d_in = 8'(i);
      bus.d_in_valid = 1'b1;
      n_cmp++;
      if (bus.d_in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL in_ready_px%0d: got %b required 1", i, bus.d_in_ready);
      end
      tick();
      n_cmp++;
      if (bus.wr_en !== 1'b1 || bus.layer_3_write_addr !== 7'(i - 1) || bus.d_out !== exp_pix(8'(i))) begin
        n_bad++;
        $display("FAIL write_px%0d: wr_en=%b addr=%0d dout=%h required 1 %0d %h",
                 i, bus.wr_en, bus.layer_3_write_addr, bus.d_out, i - 1, exp_pix(8'(i)));
      end
      n_cmp++;
      if (bus.conv_2_ready !== (i >= ready_at)) begin
        n_bad++;
        $display("FAIL c2_ready_px%0d: got %b required %b", i, bus.conv_2_ready, (i >= ready_at));
      end
    end
  endtask

  task automatic test_first_pair();
    bus.layer_3_write_begin = 1'b1;
    tick();
    stream_check(1, 48, 48);
  endtask

  task automatic test_stall();
    stream_check(49, 96, 1);
    n_cmp++;
    if (bus.d_in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_ready: got %b required 0", bus.d_in_ready);
    end
    bus.d_in = 8'h61;
    bus.d_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (bus.wr_en !== 1'b0 || bus.d_in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold%0d: wr_en=%b rdy=%b required 0 0", k, bus.wr_en, bus.d_in_ready);
      end
    end
    bus.d_in_valid = 1'b0;
  endtask

  task automatic test_release();
    bus.pair_consumed = 1'b1;
    tick();
    bus.pair_consumed = 1'b0;
    n_cmp++;
    if (bus.d_in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL release_early: d_in_ready=%b required 0", bus.d_in_ready);
    end
    tick();
    n_cmp++;
    if (bus.d_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL release_ready: d_in_ready=%b required 1", bus.d_in_ready);
    end
    bus.d_in = 8'hAA;
    bus.d_in_valid = 1'b1;
    tick();
    bus.d_in_valid = 1'b0;
    n_cmp++;
    if (bus.wr_en !== 1'b1 || bus.layer_3_write_addr !== 7'd0 || bus.d_out !== exp_pix(8'hAA)) begin
      n_bad++;
      $display("FAIL release_write: wr_en=%b addr=%0d dout=%h required 1 0 %h",
               bus.wr_en, bus.layer_3_write_addr, bus.d_out, exp_pix(8'hAA));
    end
  endtask

  task automatic test_full_frame();
    int p;
    int cyc;
    logic acc;
    logic pend_pc;
    int row;
    int col;
    int eaddr;
    bus.layer_3_write_begin = 1'b0;
    tick();
    n_cmp++;
    if (bus.conv_2_ready !== 1'b0 || bus.d_in_ready !== 1'b0 || bus.wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: c2r=%b rdy=%b wr_en=%b required 0 0 0",
               bus.conv_2_ready, bus.d_in_ready, bus.wr_en);
    end
    bus.layer_3_write_begin = 1'b1;
    tick();
    p = 0;
    cyc = 0;
    pend_pc = 1'b0;
    while (p < 576 && cyc < 2000) begin
      bus.d_in = 8'(p + 1);
      bus.d_in_valid = 1'b1;
      bus.pair_consumed = pend_pc;
      acc = bus.d_in_ready;
      tick();
      cyc++;
      pend_pc = 1'b0;
      if (acc) begin
        row = p / 24;
        col = p % 24;
        eaddr = ((row / 2) % 2) * 48 + (row % 2) * 24 + col;
        n_cmp++;
        if (bus.wr_en !== 1'b1 || bus.layer_3_write_addr !== 7'(eaddr) || bus.d_out !== exp_pix(8'(p + 1))) begin
          n_bad++;
          $display("FAIL frame_px%0d: wr_en=%b addr=%0d dout=%h required 1 %0d %h",
                   p, bus.wr_en, bus.layer_3_write_addr, bus.d_out, eaddr, exp_pix(8'(p + 1)));
        end
        if (p % 48 == 47 && p != 575) pend_pc = 1'b1;
        p++;
      end else begin
        n_cmp++;
        if (bus.wr_en !== 1'b0) begin
          n_bad++;
          $display("FAIL frame_idle_wr: wr_en=%b required 0 at pixel %0d", bus.wr_en, p);
        end
      end
    end
    bus.d_in_valid = 1'b0;
    bus.pair_consumed = 1'b0;
    n_cmp++;
    if (p != 576) begin
      n_bad++;
      $display("FAIL frame_timeout: accepted %0d pixels required 576", p);
    end
    n_cmp++;
    if (bus.conv_2_write_complete !== 1'b0 || bus.layer_3_write_addr !== 7'd95) begin
      n_bad++;
      $display("FAIL frame_last_write: cmp=%b addr=%0d required 0 95",
               bus.conv_2_write_complete, bus.layer_3_write_addr);
    end
    tick();
    n_cmp++;
    if (bus.conv_2_write_complete !== 1'b1 || bus.wr_en !== 1'b0 || bus.d_in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_complete: cmp=%b wr_en=%b rdy=%b required 1 0 0",
               bus.conv_2_write_complete, bus.wr_en, bus.d_in_ready);
    end
    bus.d_in_valid = 1'b1;
    tick();
    bus.d_in_valid = 1'b0;
    n_cmp++;
    if (bus.conv_2_write_complete !== 1'b1 || bus.conv_2_ready !== 1'b1 || bus.wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL done_hold: cmp=%b c2r=%b wr_en=%b required 1 1 0",
               bus.conv_2_write_complete, bus.conv_2_ready, bus.wr_en);
    end
    bus.layer_3_write_begin = 1'b0;
    tick();
    n_cmp++;
    if (bus.conv_2_write_complete !== 1'b0 || bus.conv_2_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL done_clear: cmp=%b c2r=%b required 0 0",
               bus.conv_2_write_complete, bus.conv_2_ready);
    end
  endtask

  task automatic test_abort_restart();
    bus.layer_3_write_begin = 1'b1;
    tick();
    for (int i = 1; i <= 30; i++) begin
      bus.d_in = 8'(i + 100);
      bus.d_in_valid = 1'b1;
      tick();
    end
    bus.d_in_valid = 1'b1;
    bus.layer_3_write_begin = 1'b0;
    tick();
    n_cmp++;
    if (bus.wr_en !== 1'b0 || bus.d_in_ready !== 1'b0 || bus.conv_2_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL abort: wr_en=%b rdy=%b c2r=%b required 0 0 0",
               bus.wr_en, bus.d_in_ready, bus.conv_2_ready);
    end
    tick();
    n_cmp++;
    if (bus.wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_write: wr_en=%b required 0", bus.wr_en);
    end
    bus.d_in_valid = 1'b0;
    stream_restart();
  endtask

  task automatic stream_restart();
    bus.layer_3_write_begin = 1'b1;
    tick();
    stream_check(1, 48, 48);
  endtask

  task automatic test_relu();
    bus.layer_3_write_begin = 1'b0;
    tick();
    bus.layer_3_write_begin = 1'b1;
    tick();
    bus.d_in = 8'hF0;
    bus.d_in_valid = 1'b1;
    tick();
    n_cmp++;
`ifdef CONV2_WR_RELU_EN
    if (bus.wr_en !== 1'b1 || bus.d_out !== 8'h00) begin
      n_bad++;
      $display("FAIL relu_neg: wr_en=%b dout=%h required 1 00", bus.wr_en, bus.d_out);
    end
`else
    if (bus.wr_en !== 1'b1 || bus.d_out !== 8'hF0) begin
      n_bad++;
      $display("FAIL relu_neg: wr_en=%b dout=%h required 1 f0", bus.wr_en, bus.d_out);
    end
`endif
    bus.d_in = 8'h12;
    tick();
    bus.d_in_valid = 1'b0;
    n_cmp++;
    if (bus.wr_en !== 1'b1 || bus.d_out !== 8'h12 || bus.layer_3_write_addr !== 7'd1) begin
      n_bad++;
      $display("FAIL relu_pos: wr_en=%b dout=%h addr=%0d required 1 12 1",
               bus.wr_en, bus.d_out, bus.layer_3_write_addr);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.layer_3_write_begin = 1'b0;
    bus.d_in = 8'h00;
    bus.d_in_valid = 1'b0;
    bus.pair_consumed = 1'b0;
    rst = 1'b0;
    test_reset();
    test_async_reset();
    test_first_pair();
    test_stall();
    test_release();
    test_full_frame();
    test_abort_restart();
    test_relu();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
